// File: rtl/rv32i_types.sv
// rtl/rv32i_types.sv - shared types for the memory responder
package rv32i_types;

    // Responder control state: waiting for work, or counting down an access.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    // Which requester owns the backing port.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } mem_port_t;

    // Latency counter width; covers LATENCY up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - byte-masked word storage, one read/write port
//
// Ports:
//   clk    - write clock
//   addr   - word index, shared by read and write
//   wen    - per-byte-lane write enable, lane i = wdata[8*i+7:8*i]
//   wdata  - write data, lane-aligned
//   rdata  - combinational read of the addressed word (pre-write contents)
module mem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] addr,
    input  logic [3:0]       wen,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    assign rdata = mem[addr];

    // No reset: contents must survive a responder reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wen[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency dual-port (fetch/data) memory responder
//
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   imem_addr, imem_rmask           - fetch request (rmask nonzero for one cycle)
//   imem_rdata, imem_resp           - fetch completion pulse and word
//   dmem_addr, dmem_rmask,
//   dmem_wmask, dmem_wdata          - load/store request (either mask nonzero)
//   dmem_rdata, dmem_resp           - data completion pulse and word
//   err                             - sticky: request hit an already-pending port
module mem_responder
    import rv32i_types::*;
#(
    parameter int LATENCY     = 4,
    parameter int DEPTH_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        err
);

    localparam int               IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    mem_state_t       state, state_n;
    mem_port_t        svc, svc_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    logic             i_pend, d_pend;
    logic [IDX_W-1:0] i_idx, d_idx;
    logic [3:0]       d_wm;
    logic [31:0]      d_wd;

    logic             i_req, d_req;
    logic             i_resp_c, d_resp_c;
    logic             i_accept, d_accept;
    logic             i_pend_n, d_pend_n;

    logic [IDX_W-1:0] arr_addr;
    logic [3:0]       arr_wen;
    logic [31:0]      arr_rdata;

    // Byte offset and bits above the array size are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{imem_addr[31:IDX_W+2], imem_addr[1:0],
                                dmem_addr[31:IDX_W+2], dmem_addr[1:0]};

    assign i_req = |imem_rmask;
    assign d_req = (|dmem_rmask) | (|dmem_wmask);

    assign i_resp_c = (state == BUSY) && (cnt == '0) && (svc == PORT_I);
    assign d_resp_c = (state == BUSY) && (cnt == '0) && (svc == PORT_D);

    // A slot frees up in its own resp cycle, so a request landing then is taken.
    assign i_accept = i_req && (!i_pend || i_resp_c);
    assign d_accept = d_req && (!d_pend || d_resp_c);

    // Pending view after this edge; the FSM uses it so fresh requests start at once.
    assign i_pend_n = i_accept || (i_pend && !i_resp_c);
    assign d_pend_n = d_accept || (d_pend && !d_resp_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            svc    <= PORT_I;
            cnt    <= '0;
            i_pend <= 1'b0;
            d_pend <= 1'b0;
            i_idx  <= '0;
            d_idx  <= '0;
            d_wm   <= '0;
            d_wd   <= '0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            svc    <= svc_n;
            cnt    <= cnt_n;
            i_pend <= i_pend_n;
            d_pend <= d_pend_n;
            if (i_accept) begin
                i_idx <= imem_addr[IDX_W+1:2];
            end
            if (d_accept) begin
                d_idx <= dmem_addr[IDX_W+1:2];
                d_wm  <= dmem_wmask;
                d_wd  <= dmem_wdata;
            end
            if ((i_req && !i_accept) || (d_req && !d_accept)) begin
                err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        svc_n   = svc;
        cnt_n   = cnt;
        unique case (state)
            IDLE: begin
                if (d_pend_n) begin
                    state_n = BUSY;
                    svc_n   = PORT_D;
                    cnt_n   = CNT_LOAD;
                end else if (i_pend_n) begin
                    state_n = BUSY;
                    svc_n   = PORT_I;
                    cnt_n   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (svc == PORT_D && i_pend_n) begin
                    svc_n = PORT_I;
                    cnt_n = CNT_LOAD;
                end else if (svc == PORT_I && d_pend_n) begin
                    svc_n = PORT_D;
                    cnt_n = CNT_LOAD;
                end else if (svc == PORT_D && d_pend_n) begin
                    cnt_n = CNT_LOAD;
                end else if (svc == PORT_I && i_pend_n) begin
                    cnt_n = CNT_LOAD;
                end else begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign arr_addr = (svc == PORT_D) ? d_idx : i_idx;
    // Write lands on the edge closing the resp cycle, after rdata sampled old data.
    assign arr_wen  = d_resp_c ? d_wm : 4'b0000;

    mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_mem_array (
        .clk  (clk),
        .addr (arr_addr),
        .wen  (arr_wen),
        .wdata(d_wd),
        .rdata(arr_rdata)
    );

    assign imem_resp  = i_resp_c;
    assign dmem_resp  = d_resp_c;
    assign imem_rdata = i_resp_c ? arr_rdata : 32'h0;
    assign dmem_rdata = d_resp_c ? arr_rdata : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder
module tb_mem_responder;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr = '0;
    logic [3:0]  imem_rmask = '0;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr = '0;
    logic [3:0]  dmem_rmask = '0;
    logic [3:0]  dmem_wmask = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        err;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          i_n = 0, d_n = 0, i_cyc = 0, d_cyc = 0;
    logic [31:0] i_dat = '0, d_dat = '0;
    int          overlap = 0, rz_bad = 0;

    mem_responder #(.LATENCY(LAT), .DEPTH_WORDS(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata),
        .imem_resp (imem_resp),
        .dmem_addr (dmem_addr),
        .dmem_rmask(dmem_rmask),
        .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .dmem_resp (dmem_resp),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One cycle: sample outputs mid-cycle, then drop all request strobes.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (imem_resp) begin i_n++; i_cyc = cyc; i_dat = imem_rdata; end
        else if (imem_rdata !== 32'h0) rz_bad++;
        if (dmem_resp) begin d_n++; d_cyc = cyc; d_dat = dmem_rdata; end
        else if (dmem_rdata !== 32'h0) rz_bad++;
        if (imem_resp && dmem_resp) overlap++;
        imem_rmask = '0;
        dmem_rmask = '0;
        dmem_wmask = '0;
    endtask

    task automatic d_access(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                            input logic [31:0] wd, output logic [31:0] data, output int lat);
        int start, n0;
        tick();
        dmem_addr = a; dmem_rmask = rm; dmem_wmask = wm; dmem_wdata = wd;
        start = cyc; n0 = d_n;
        for (int k = 0; k < 40 && d_n == n0; k++) tick();
        chk("d_resp_seen", d_n - n0, 1);
        lat  = d_cyc - start;
        data = d_dat;
    endtask

    initial begin
        logic [31:0] data;
        int          lat, start, start2, n0, m0;

        // Reset state, and a fetch presented during reset must be ignored.
        tick();
        chk("rst_imem_resp", imem_resp, 0);
        chk("rst_dmem_resp", dmem_resp, 0);
        chk("rst_err", err, 0);
        imem_addr = 32'h0; imem_rmask = 4'hF;
        tick();
        rst = 1'b0;
        repeat (10) tick();
        chk("no_resp_for_rst_req", i_n, 0);

        // Store then load, basic latency.
        d_access(32'h10, 4'h0, 4'hF, 32'hDEADBEEF, data, lat);
        chk("store_lat", lat, LAT);
        d_access(32'h10, 4'hF, 4'h0, 32'h0, data, lat);
        chk("load_lat", lat, LAT);
        chk("load_data", data, 32'hDEADBEEF);

        // Partial-lane store.
        d_access(32'h20, 4'h0, 4'hF, 32'h11223344, data, lat);
        d_access(32'h20, 4'h0, 4'h2, 32'h0000AA00, data, lat);
        d_access(32'h20, 4'hF, 4'h0, 32'h0, data, lat);
        chk("byte_lane_merge", data, 32'h1122AA44);

        // Address wrap modulo DEPTH_WORDS.
        d_access(32'h1000, 4'h0, 4'hF, 32'hCAFEF00D, data, lat);
        d_access(32'h0, 4'hF, 4'h0, 32'h0, data, lat);
        chk("addr_wrap", data, 32'hCAFEF00D);

        // Read and write in one access: old data returned, new data stored.
        d_access(32'h20, 4'hF, 4'hF, 32'h55667788, data, lat);
        chk("rw_read_old", data, 32'h1122AA44);
        d_access(32'h20, 4'hF, 4'h0, 32'h0, data, lat);
        chk("rw_write_new", data, 32'h55667788);

        // Simultaneous fetch and load: dmem first, imem one latency later.
        d_access(32'h4, 4'h0, 4'hF, 32'h0BADC0DE, data, lat);
        tick();
        imem_addr = 32'h0; imem_rmask = 4'hF;
        dmem_addr = 32'h4; dmem_rmask = 4'hF;
        start = cyc; n0 = i_n; m0 = d_n;
        for (int k = 0; k < 40 && i_n == n0; k++) tick();
        chk("arb_d_lat", d_cyc - start, LAT);
        chk("arb_i_lat", i_cyc - start, 2 * LAT);
        chk("arb_d_data", d_dat, 32'h0BADC0DE);
        chk("arb_i_data", i_dat, 32'hCAFEF00D);
        chk("arb_counts", (i_n - n0) * 16 + (d_n - m0), 32'h11);

        // Fetch issued in the previous fetch's resp cycle is accepted.
        tick();
        imem_addr = 32'h10; imem_rmask = 4'hF;
        start = cyc; n0 = i_n;
        for (int k = 0; k < 40 && i_n == n0; k++) tick();
        chk("b2b_first_lat", i_cyc - start, LAT);
        chk("b2b_first_data", i_dat, 32'hDEADBEEF);
        imem_addr = 32'h20; imem_rmask = 4'hF;
        start2 = cyc; n0 = i_n;
        for (int k = 0; k < 40 && i_n == n0; k++) tick();
        chk("b2b_second_lat", i_cyc - start2, LAT);
        chk("b2b_second_data", i_dat, 32'h55667788);
        chk("b2b_no_err", err, 0);

        // Second fetch while first pending: error, dropped, first unchanged.
        tick();
        imem_addr = 32'h10; imem_rmask = 4'hF;
        start = cyc; n0 = i_n;
        tick(); tick();
        imem_addr = 32'h4; imem_rmask = 4'hF;
        repeat (12) tick();
        chk("ovr_resp_count", i_n - n0, 1);
        chk("ovr_lat", i_cyc - start, LAT);
        chk("ovr_data", i_dat, 32'hDEADBEEF);
        chk("ovr_err_set", err, 1);
        repeat (5) tick();
        chk("ovr_err_sticky", err, 1);

        // Asynchronous reset during a resp cycle drops outputs at once.
        tick();
        imem_addr = 32'h10; imem_rmask = 4'hF;
        n0 = i_n;
        for (int k = 0; k < 40 && !imem_resp; k++) begin
            @(negedge clk);
            imem_rmask = '0;
        end
        #1 rst = 1'b1;
        #1;
        chk("async_rst_imem_resp", imem_resp, 0);
        chk("async_rst_imem_rdata", imem_rdata, 0);
        chk("async_rst_err", err, 0);
        tick(); tick();
        rst = 1'b0;

        // Reset in cycle 2 of a pending store: no resp, no write.
        tick();
        dmem_addr = 32'h10; dmem_wmask = 4'hF; dmem_wdata = 32'h12345678;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("rst_store_dmem_resp", dmem_resp, 0);
        chk("rst_store_dmem_rdata", dmem_rdata, 0);
        tick();
        rst = 1'b0;
        m0 = d_n;
        repeat (10) tick();
        chk("rst_store_no_resp", d_n - m0, 0);
        d_access(32'h10, 4'hF, 4'h0, 32'h0, data, lat);
        chk("rst_store_word_kept", data, 32'hDEADBEEF);

        chk("never_both_resp", overlap, 0);
        chk("rdata_zero_without_resp", rz_bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
